// File: rtl/ex_stage_if.sv
// Data-bus bundle between the execute stage and data memory.
// One outstanding request; ack is a single-cycle pulse.
interface ex_stage_if #(
  parameter int MEM_ADDR_W = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_sel_o;
  logic                  mem_ack_i;
  logic [31:0]           mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    output mem_sel_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_sel_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch/jump resolution and a
// single-outstanding load/store engine that holds ID while busy.
module ex_stage #(
  parameter int MEM_ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg1_rdata_i,
  input  logic [31:0] reg2_rdata_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] op1_jump_i,
  input  logic [31:0] op2_jump_i,
  ex_stage_if.master  mem,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [2:0]  hold_flag_o,
  output logic        misalign_o
);

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t state;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_lui, is_auipc, is_opimm, is_op;
  logic        is_jal, is_jalr, is_branch;
  logic        is_load, is_store;
  logic        is_alu, ld_ok, st_ok, mem_op;
  logic [31:0] alu_res;
  logic [4:0]  sh;
  logic        taken;
  logic [31:0] jtgt;
  logic [31:0] ea;
  logic        misal;
  logic        go;
  logic [31:0] st_wdata;
  logic [3:0]  st_sel;

  logic                  req_q;
  logic                  we_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            sel_q;
  logic [31:0]           rdata_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic        unused_inst;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];

  assign is_lui    = opc == OPC_LUI;
  assign is_auipc  = opc == OPC_AUIPC;
  assign is_opimm  = opc == OPC_OPIMM;
  assign is_op     = opc == OPC_OP;
  assign is_jal    = opc == OPC_JAL;
  assign is_jalr   = opc == OPC_JALR;
  assign is_branch = opc == OPC_BRANCH;
  assign is_load   = opc == OPC_LOAD;
  assign is_store  = opc == OPC_STORE;

  assign is_alu = is_lui | is_auipc | is_opimm | is_op;
  assign ld_ok  = is_load &
                  (f3 inside {3'b000, 3'b001, 3'b010,
                              3'b100, 3'b101});
  assign st_ok  = is_store &
                  (f3 inside {3'b000, 3'b001, 3'b010});
  assign mem_op = ld_ok | st_ok;

  assign unused_inst = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

  // inst_i[30] selects SUB only for register-register ops
  assign sh = op2_i[4:0];

  always_comb begin
    alu_res = '0;
    if (is_lui | is_auipc) begin
      alu_res = op1_i + op2_i;
    end else begin
      unique case (f3)
        3'b000: alu_res = (is_op & inst_i[30]) ?
                          op1_i - op2_i : op1_i + op2_i;
        3'b001: alu_res = op1_i << sh;
        3'b010: alu_res = {31'd0,
                           $signed(op1_i) < $signed(op2_i)};
        3'b011: alu_res = {31'd0, op1_i < op2_i};
        3'b100: alu_res = op1_i ^ op2_i;
        3'b101: alu_res = inst_i[30] ?
                          32'($signed(op1_i) >>> sh) :
                          op1_i >> sh;
        3'b110: alu_res = op1_i | op2_i;
        3'b111: alu_res = op1_i & op2_i;
      endcase
    end
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = reg1_rdata_i == reg2_rdata_i;
      3'b001: taken = reg1_rdata_i != reg2_rdata_i;
      3'b100: taken = $signed(reg1_rdata_i) <
                      $signed(reg2_rdata_i);
      3'b101: taken = $signed(reg1_rdata_i) >=
                      $signed(reg2_rdata_i);
      3'b110: taken = reg1_rdata_i < reg2_rdata_i;
      3'b111: taken = reg1_rdata_i >= reg2_rdata_i;
      default: taken = 1'b0;
    endcase
  end

  assign jtgt = (op1_jump_i + op2_jump_i) &
                {31'h7fffffff, ~is_jalr};

  assign ea    = op1_i + op2_i;
  assign misal = (f3[1:0] == 2'b01 & ea[0]) |
                 (f3[1:0] == 2'b10 & (ea[1:0] != 2'b00));

  assign go         = (state == S_IDLE) & mem_op & ~misal;
  assign misalign_o = (state == S_IDLE) & mem_op & misal;
  assign hold_flag_o = (go | state == S_REQ) ? HOLD_ID : HOLD_NONE;

  always_comb begin
    st_wdata = '0;
    st_sel   = 4'b1111;
    if (st_ok) begin
      case (f3[1:0])
        2'b00: begin
          st_wdata = {4{reg2_rdata_i[7:0]}};
          st_sel   = 4'b0001 << ea[1:0];
        end
        2'b01: begin
          st_wdata = {2{reg2_rdata_i[15:0]}};
          st_sel   = 4'b0011 << ea[1:0];
        end
        default: st_wdata = reg2_rdata_i;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_REQ;
            req_q   <= 1'b1;
            we_q    <= st_ok;
            addr_q  <= {ea[MEM_ADDR_W-1:2], 2'b00};
            wdata_q <= st_wdata;
            sel_q   <= st_sel;
            off_q   <= ea[1:0];
            f3_q    <= f3;
          end
        end
        S_REQ: begin
          if (mem.mem_ack_i) begin
            state   <= S_DONE;
            req_q   <= 1'b0;
            rdata_q <= mem.mem_rdata_i;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_sel_o   = sel_q;

  assign ld_b = rdata_q[{off_q, 3'b000} +: 8];
  assign ld_h = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'd0, ld_b};
      3'b101:  ld_data = {16'd0, ld_h};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    reg_we_o    = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    unique case (1'b1)
      is_alu: begin
        reg_we_o    = reg_we_i;
        reg_waddr_o = reg_waddr_i;
        reg_wdata_o = alu_res;
      end
      is_jal, is_jalr: begin
        reg_we_o    = reg_we_i;
        reg_waddr_o = reg_waddr_i;
        reg_wdata_o = inst_addr_i + 32'd4;
        jump_flag_o = 1'b1;
        jump_addr_o = jtgt;
      end
      is_branch: begin
        jump_flag_o = taken;
        jump_addr_o = taken ? jtgt : 32'd0;
      end
      mem_op: begin
        reg_waddr_o = reg_waddr_i;
        if (ld_ok && state == S_DONE) begin
          reg_we_o    = 1'b1;
          reg_wdata_o = ld_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: spec-level model checked every
// cycle, plus hand-computed literal pins.
module tb_ex_stage;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, r1, r2, op1, op2, j1, j2;
  logic        rwe_i;
  logic [4:0]  rwaddr_i;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold;
  logic        misalign;

  ex_stage_if #(.MEM_ADDR_W(32)) mem_if ();

  ex_stage #(.MEM_ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst),
    .inst_addr_i  (pc),
    .reg_we_i     (rwe_i),
    .reg_waddr_i  (rwaddr_i),
    .reg1_rdata_i (r1),
    .reg2_rdata_i (r2),
    .op1_i        (op1),
    .op2_i        (op2),
    .op1_jump_i   (j1),
    .op2_jump_i   (j2),
    .mem          (mem_if.master),
    .reg_we_o     (reg_we),
    .reg_waddr_o  (reg_waddr),
    .reg_wdata_o  (reg_wdata),
    .jump_flag_o  (jump_flag),
    .jump_addr_o  (jump_addr),
    .hold_flag_o  (hold),
    .misalign_o   (misalign)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model state: each presented instruction gets a sequence
  // number; an access is complete once an ack hit its request.
  int          seq = 0;
  int          start_cyc = 0;
  int          cyc_cnt = 0;
  int          ack_seq = -1;
  logic [31:0] cap = '0;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hold;
    logic        misal;
    logic        req;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  msel;
  } exp_t;

  function automatic logic [31:0] alu_ref(input logic [2:0] f,
      input bit alt, input bit is_reg,
      input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return (alt && is_reg) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit br_ref(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [6:0]  opc;
    logic [2:0]  f;
    logic [31:0] ea, v, tgt;
    int          size;
    bit          ld, st, done;
    e   = '0;
    opc = inst[6:0];
    f   = inst[14:12];
    tgt = j1 + j2;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        e.we = rwe_i; e.waddr = rwaddr_i; e.wdata = op1 + op2;
      end
      OPC_OPIMM, OPC_OP: begin
        e.we = rwe_i; e.waddr = rwaddr_i;
        e.wdata = alu_ref(f, inst[30], opc == OPC_OP, op1, op2);
      end
      OPC_JAL, OPC_JALR: begin
        e.we = rwe_i; e.waddr = rwaddr_i; e.wdata = pc + 4;
        e.jf = 1'b1;
        e.ja = (opc == OPC_JALR) ? (tgt & ~32'd1) : tgt;
      end
      OPC_BRANCH: begin
        e.jf = br_ref(f, r1, r2);
        e.ja = e.jf ? tgt : 32'd0;
      end
      OPC_LOAD, OPC_STORE: begin
        ld = opc == OPC_LOAD && f inside {0, 1, 2, 4, 5};
        st = opc == OPC_STORE && f inside {0, 1, 2};
        if (ld || st) begin
          e.waddr = rwaddr_i;
          size = 1 << f[1:0];
          ea = op1 + op2;
          done = ack_seq == seq;
          if ((ea[1:0] & 2'(size - 1)) != 0) begin
            e.misal = 1'b1;
          end else if (done) begin
            if (ld) begin
              e.we = 1'b1;
              v = cap >> (8 * ea[1:0]);
              if (size == 1) v = v & 32'hff;
              if (size == 2) v = v & 32'hffff;
              if (!f[2] && size == 1 && v[7]) v = v | 32'hffffff00;
              if (!f[2] && size == 2 && v[15]) v = v | 32'hffff0000;
              e.wdata = v;
            end
          end else begin
            e.hold = 3'b011;
            if (cyc_cnt - start_cyc >= 1) begin
              e.req   = 1'b1;
              e.mwe   = st;
              e.maddr = ea & ~32'd3;
              e.msel  = 4'b1111;
              if (st && size == 1) begin
                e.mwdata = {4{r2[7:0]}};
                e.msel   = 4'b0001 << ea[1:0];
              end else if (st && size == 2) begin
                e.mwdata = {2{r2[15:0]}};
                e.msel   = 4'b0011 << ea[1:0];
              end else if (st) begin
                e.mwdata = r2;
              end
            end
          end
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = model_out();
    if (!rst && e.req && mem_if.mem_ack_i) begin
      ack_seq <= seq;
      cap     <= mem_if.mem_rdata_i;
    end
    cyc_cnt <= cyc_cnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      e = model_out();
      chk("reg_we", 32'(reg_we), 32'(e.we));
      chk("reg_waddr", 32'(reg_waddr), 32'(e.waddr));
      chk("reg_wdata", reg_wdata, e.wdata);
      chk("jump_flag", 32'(jump_flag), 32'(e.jf));
      chk("jump_addr", jump_addr, e.ja);
      chk("hold", 32'(hold), 32'(e.hold));
      chk("misalign", 32'(misalign), 32'(e.misal));
      chk("mem_req", 32'(mem_if.mem_req_o), 32'(e.req));
      if (e.req) begin
        chk("mem_we", 32'(mem_if.mem_we_o), 32'(e.mwe));
        chk("mem_addr", mem_if.mem_addr_o, e.maddr);
        chk("mem_wdata", mem_if.mem_wdata_o, e.mwdata);
        chk("mem_sel", 32'(mem_if.mem_sel_o), 32'(e.msel));
      end
    end
  end

  task automatic present(input logic [31:0] i, input logic [31:0] p,
      input logic we, input logic [4:0] wa,
      input logic [31:0] a1, input logic [31:0] a2,
      input logic [31:0] o1, input logic [31:0] o2,
      input logic [31:0] t1, input logic [31:0] t2);
    inst = i; pc = p; rwe_i = we; rwaddr_i = wa;
    r1 = a1; r2 = a2; op1 = o1; op2 = o2; j1 = t1; j2 = t2;
    seq = seq + 1;
    start_cyc = cyc_cnt;
  endtask

  task automatic nop();
    present(32'h13, 0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [2:0] f,
      input bit alt, input logic [6:0] opc);
    return {1'b0, alt, 5'd0, 5'd3, 5'd4, f, 5'd6, opc};
  endfunction

  task automatic alu(input string name, input logic [31:0] i,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] expv);
    present(i, 0, 1'b1, 5'd6, 0, 0, a, b, 0, 0);
    @(negedge clk);
    chk(name, reg_wdata, expv);
    next_cyc();
  endtask

  logic [31:0] o_hold[8], o_req[8], o_addr[8], o_mwe[8];
  logic [31:0] o_sel[8], o_mwd[8], o_rwe[8], o_rwd[8];

  // c = 0 idle/hold, 1..w request, ack during w, w+1 writeback
  task automatic mem_run(input logic [31:0] i, input logic [31:0] b,
      input logic [31:0] off, input logic [31:0] data2,
      input logic we, input int w, input logic [31:0] rdata);
    present(i, 0, we, 5'd7, 0, data2, b, off, 0, 0);
    for (int c = 0; c <= w + 1; c++) begin
      mem_if.mem_ack_i   = (c == w);
      mem_if.mem_rdata_i = (c == w) ? rdata : $urandom;
      @(negedge clk);
      o_hold[c] = 32'(hold);
      o_req[c]  = 32'(mem_if.mem_req_o);
      o_addr[c] = mem_if.mem_addr_o;
      o_mwe[c]  = 32'(mem_if.mem_we_o);
      o_sel[c]  = 32'(mem_if.mem_sel_o);
      o_mwd[c]  = mem_if.mem_wdata_o;
      o_rwe[c]  = 32'(reg_we);
      o_rwd[c]  = reg_wdata;
      next_cyc();
    end
    mem_if.mem_ack_i = 1'b0;
  endtask

  function automatic logic [31:0] ld_i(input logic [2:0] f);
    return {12'd0, 5'd1, f, 5'd7, OPC_LOAD};
  endfunction

  function automatic logic [31:0] st_i(input logic [2:0] f);
    return {7'd0, 5'd2, 5'd1, f, 5'd0, OPC_STORE};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_if.mem_ack_i = 1'b0;
    mem_if.mem_rdata_i = '0;
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_if.mem_req_o), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_jump", 32'(jump_flag), 0);
    chk("rst_misal", 32'(misalign), 0);
    chk("rst_addr", mem_if.mem_addr_o, 0);
    chk("rst_sel", 32'(mem_if.mem_sel_o), 0);
    chk("rst_mwe", 32'(mem_if.mem_we_o), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    next_cyc();

    present(rtype(3'd0, 0, OPC_OP), 0, 1'b1, 5'd5,
            0, 0, 32'd7, 32'hfffffffe, 0, 0);
    @(negedge clk);
    chk("add_wdata", reg_wdata, 32'd5);
    chk("add_we", 32'(reg_we), 1);
    chk("add_waddr", 32'(reg_waddr), 5);
    next_cyc();

    alu("sub", rtype(3'd0, 1, OPC_OP), 5, 7, 32'hfffffffe);
    alu("sll", rtype(3'd1, 0, OPC_OP), 1, 32'h23, 32'd8);
    alu("slt", rtype(3'd2, 0, OPC_OP), 32'hffffffff, 1, 1);
    alu("sltu", rtype(3'd3, 0, OPC_OP), 32'hffffffff, 1, 0);
    alu("xor", rtype(3'd4, 0, OPC_OP), 32'hf0f0f0f0,
        32'hff00ff00, 32'h0ff00ff0);
    alu("srl", rtype(3'd5, 0, OPC_OP), 32'h80000000, 4,
        32'h08000000);
    alu("sra", rtype(3'd5, 1, OPC_OP), 32'h80000000, 4,
        32'hf8000000);
    alu("or", rtype(3'd6, 0, OPC_OP), 32'h0f, 32'hf0, 32'hff);
    alu("and", rtype(3'd7, 0, OPC_OP), 32'hff, 32'h3c, 32'h3c);
    alu("srai", rtype(3'd5, 1, OPC_OPIMM), 32'hffff0000,
        32'h408, 32'hffffff00);
    alu("addi_b30", rtype(3'd0, 1, OPC_OPIMM), 5, 7, 32'd12);
    alu("lui", {20'h12345, 5'd6, OPC_LUI}, 32'h12345000, 0,
        32'h12345000);
    alu("auipc", {20'h1, 5'd6, OPC_AUIPC}, 32'h100, 32'h1000,
        32'h1100);

    present({25'd0, OPC_JAL}, 32'h200, 1'b1, 5'd1,
            0, 0, 0, 0, 32'h200, 32'h10);
    @(negedge clk);
    chk("jal_addr", jump_addr, 32'h210);
    chk("jal_link", reg_wdata, 32'h204);
    next_cyc();
    present({20'd0, 5'd1, OPC_JALR}, 32'h300, 1'b1, 5'd1,
            0, 0, 0, 0, 32'h301, 32'h4);
    @(negedge clk);
    chk("jalr_addr", jump_addr, 32'h304);
    next_cyc();

    present({7'd0, 5'd2, 5'd1, 3'b100, 5'd0, OPC_BRANCH}, 32'h100,
            1'b0, 5'd0, 32'hffffffff, 1, 0, 0, 32'h100, 32'h20);
    @(negedge clk);
    chk("blt_flag", 32'(jump_flag), 1);
    chk("blt_addr", jump_addr, 32'h120);
    next_cyc();
    present({7'd0, 5'd2, 5'd1, 3'b110, 5'd0, OPC_BRANCH}, 32'h100,
            1'b0, 5'd0, 32'hffffffff, 1, 0, 0, 32'h100, 32'h20);
    @(negedge clk);
    chk("bltu_flag", 32'(jump_flag), 0);
    next_cyc();
    for (int f = 0; f < 8; f++) begin
      present({7'd0, 5'd2, 5'd1, 3'(f), 5'd0, OPC_BRANCH}, 32'h40,
              1'b0, 5'd0, 32'h9, 32'h9, 0, 0, 32'h40, 32'h8);
      next_cyc();
    end

    present(32'h0000007f, 0, 1'b1, 5'd6, 1, 2, 3, 4, 5, 6);
    next_cyc();

    mem_run(ld_i(3'b000), 32'h1000, 3, 0, 1'b1, 3, 32'h80112233);
    for (int c = 0; c < 4; c++) chk("lb_hold", o_hold[c], 3);
    chk("lb_hold_done", o_hold[4], 0);
    for (int c = 1; c < 4; c++) chk("lb_addr", o_addr[c], 32'h1000);
    chk("lb_wdata", o_rwd[4], 32'hffffff80);
    chk("lb_we", o_rwe[4], 1);

    mem_run(st_i(3'b001), 32'h2000, 2, 32'habcd1234, 1'b0, 1, 0);
    chk("sh_mwe", o_mwe[1], 1);
    chk("sh_sel", o_sel[1], 32'b1100);
    chk("sh_wdata", o_mwd[1], 32'h12341234);
    chk("sh_we_done", o_rwe[2], 0);

    mem_run(st_i(3'b000), 32'h4000, 1, 32'h55, 1'b0, 2, 0);
    chk("sb_sel", o_sel[1], 32'b0010);
    chk("sb_wdata", o_mwd[1], 32'h55555555);
    mem_run(st_i(3'b010), 32'h4000, 8, 32'h01234567, 1'b0, 1, 0);
    mem_run(ld_i(3'b101), 32'h3000, 2, 0, 1'b1, 2, 32'h87654321);
    chk("lhu_wdata", o_rwd[3], 32'h00008765);
    mem_run(ld_i(3'b001), 32'h3000, 0, 0, 1'b1, 1, 32'h0000f00f);
    mem_run(ld_i(3'b100), 32'h3000, 1, 0, 1'b1, 1, 32'h0000ab00);
    mem_run(ld_i(3'b010), 32'h3000, 4, 0, 1'b1, 2, 32'hdeadbeef);

    present(ld_i(3'b010), 0, 1'b1, 5'd7, 0, 0, 32'h2000, 1, 0, 0);
    @(negedge clk);
    chk("mis_pulse", 32'(misalign), 1);
    chk("mis_req", 32'(mem_if.mem_req_o), 0);
    chk("mis_hold", 32'(hold), 0);
    chk("mis_we", 32'(reg_we), 0);
    next_cyc();
    nop();
    @(negedge clk);
    chk("mis_end", 32'(misalign), 0);
    chk("mis_req_after", 32'(mem_if.mem_req_o), 0);
    next_cyc();

    present(ld_i(3'b010), 0, 1'b1, 5'd7, 0, 0, 32'h5000, 0, 0, 0);
    next_cyc();
    @(negedge clk);
    chk("abort_req_pre", 32'(mem_if.mem_req_o), 1);
    #2;
    rst = 1'b1;
    nop();
    #1;
    chk("abort_req", 32'(mem_if.mem_req_o), 0);
    chk("abort_hold", 32'(hold), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cyc();
    mem_if.mem_ack_i = 1'b1;
    mem_if.mem_rdata_i = 32'h12345678;
    @(negedge clk);
    chk("late_ack_we", 32'(reg_we), 0);
    next_cyc();
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_we2", 32'(reg_we), 0);
    chk("late_ack_hold", 32'(hold), 0);
    next_cyc();

    mem_run(ld_i(3'b010), 32'h6000, 0, 0, 1'b1, 1, 32'hcafef00d);
    chk("post_rst_hold", o_hold[0], 3);
    chk("post_rst_req", o_req[1], 1);
    chk("post_rst_wdata", o_rwd[2], 32'hcafef00d);

    nop();
    repeat (3) next_cyc();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
